// File: rtl/if_stage.sv
// Instruction-fetch stage of the RV32I core: owns the PC, drives the
// instruction-memory address and fills the IF/ID pipeline register.
module if_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Stall,
    input  logic [1:0]            PCSrc,
    input  logic [DATA_WIDTH-1:0] PCE,
    input  logic [DATA_WIDTH-1:0] ImmExtE,
    input  logic [DATA_WIDTH-1:0] ALUResultE,
    output logic [DATA_WIDTH-1:0] InstrAddr,
    input  logic [DATA_WIDTH-1:0] InstrRData,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic                  MisalignFault,
    output logic [31:0]           FetchCount
);

    typedef enum logic {
        RUN     = 1'b0,
        FLUSHED = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_pcd;
    logic [DATA_WIDTH-1:0] r_pcp4;
    logic                  r_valid;
    logic                  r_fault;
    logic [31:0]           r_count;

    logic [DATA_WIDTH-1:0] w_seq;
    logic [DATA_WIDTH-1:0] w_branch;
    logic [DATA_WIDTH-1:0] w_jalr;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_redirect;
    logic                  w_misalign;

    // Next-PC candidates and redirect decode; PCSrc=11 falls through as sequential
    always_comb begin
        w_seq      = r_pc + DATA_WIDTH'(4);
        w_branch   = PCE + ImmExtE;
        w_jalr     = ALUResultE & ~DATA_WIDTH'(1);
        w_redirect = (PCSrc == 2'b01) || (PCSrc == 2'b10);
        w_target   = (PCSrc == 2'b10) ? w_jalr : w_branch;
        w_misalign = (w_target[1:0] != 2'b00);
    end

    // PC, IF/ID register and fetch FSM; redirect beats stall, stall beats fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_pcd   <= '0;
            r_pcp4  <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_count <= '0;
        end else if (w_redirect) begin
            // The fault is sticky, but the PC still takes the word-aligned target
            r_state <= FLUSHED;
            r_pc    <= w_target & ~DATA_WIDTH'(3);
            r_instr <= NOP_INSTR;
            r_pcd   <= '0;
            r_pcp4  <= '0;
            r_valid <= 1'b0;
            if (w_misalign) begin
                r_fault <= 1'b1;
            end
        end else if (!Stall) begin
            if (r_state == FLUSHED) begin
                r_state <= RUN;
            end
            r_pc    <= w_seq;
            r_instr <= InstrRData;
            r_pcd   <= r_pc;
            r_pcp4  <= w_seq;
            r_valid <= 1'b1;
            r_count <= r_count + 32'd1;
        end
    end

    assign InstrAddr     = r_pc;
    assign InstrD        = r_instr;
    assign PCD           = r_pcd;
    assign PCPlus4D      = r_pcp4;
    assign ValidD        = r_valid;
    assign MisalignFault = r_fault;
    assign FetchCount    = r_count;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Stall = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] PCE = '0;
    logic [31:0] ImmExtE = '0;
    logic [31:0] ALUResultE = '0;
    logic [31:0] InstrAddr;
    logic [31:0] InstrRData;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        MisalignFault;
    logic [31:0] FetchCount;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Memory image: every word carries its own address
    assign InstrRData = 32'hA000_0000 | InstrAddr;

    if_stage dut (
        .clk(clk), .rst(rst), .Stall(Stall), .PCSrc(PCSrc),
        .PCE(PCE), .ImmExtE(ImmExtE), .ALUResultE(ALUResultE),
        .InstrAddr(InstrAddr), .InstrRData(InstrRData),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .MisalignFault(MisalignFault), .FetchCount(FetchCount)
    );

    always #5 clk = ~clk;

    // Behavioural model of the architectural state
    logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_cnt;
    logic        m_valid, m_fault;

    function automatic logic [31:0] target_of(logic [1:0] src, logic [31:0] pce,
                                              logic [31:0] imm, logic [31:0] alu);
        if (src == 2'd1) return pce + imm;
        return {alu[31:1], 1'b0};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= 32'h0; m_instr <= 32'h13; m_pcd <= 0; m_pcp4 <= 0;
            m_valid <= 0; m_fault <= 0; m_cnt <= 0;
        end else if (PCSrc == 2'd1 || PCSrc == 2'd2) begin
            if (target_of(PCSrc, PCE, ImmExtE, ALUResultE) % 4 != 0) m_fault <= 1'b1;
            m_pc    <= target_of(PCSrc, PCE, ImmExtE, ALUResultE) / 4 * 4;
            m_instr <= 32'h13; m_pcd <= 0; m_pcp4 <= 0; m_valid <= 0;
        end else if (!Stall) begin
            m_instr <= 32'hA000_0000 | m_pc;
            m_pcd   <= m_pc;
            m_pcp4  <= m_pc + 4;
            m_pc    <= m_pc + 4;
            m_valid <= 1'b1;
            m_cnt   <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.InstrAddr", InstrAddr, m_pc);
            chk("m.InstrD", InstrD, m_instr);
            chk("m.PCD", PCD, m_pcd);
            chk("m.PCPlus4D", PCPlus4D, m_pcp4);
            chk("m.ValidD", {31'b0, ValidD}, {31'b0, m_valid});
            chk("m.Misalign", {31'b0, MisalignFault}, {31'b0, m_fault});
            chk("m.FetchCount", FetchCount, m_cnt);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        step(2);
        chk("rst.pc", InstrAddr, 32'h0);
        chk("rst.instr", InstrD, 32'h13);
        chk("rst.valid", {31'b0, ValidD}, 32'h0);
        chk("rst.count", FetchCount, 32'h0);
        rst = 1'b0;

        // Three normal fetches
        chk("seq.a0", InstrAddr, 32'h0);
        step(1); chk("seq.a1", InstrAddr, 32'h4);
        step(1); chk("seq.a2", InstrAddr, 32'h8);
        step(1);
        chk("seq.pcd", PCD, 32'h8);
        chk("seq.pcp4", PCPlus4D, 32'hC);
        chk("seq.instr", InstrD, 32'hA000_0008);
        chk("seq.valid", {31'b0, ValidD}, 32'h1);
        chk("seq.count", FetchCount, 32'd3);
        step(1); chk("seq.pc10", InstrAddr, 32'h10);

        // Stall for two edges at PC 0x10
        Stall = 1'b1;
        step(2);
        chk("stall.pc", InstrAddr, 32'h10);
        chk("stall.pcd", PCD, 32'hC);
        chk("stall.count", FetchCount, 32'd4);
        Stall = 1'b0;
        step(1);
        chk("unstall.instr", InstrD, 32'hA000_0010);
        chk("unstall.pc", InstrAddr, 32'h14);

        // Branch -16 from 0x20 while stalled: redirect wins
        PCE = 32'h20; ImmExtE = 32'hFFFF_FFF0; PCSrc = 2'b01; Stall = 1'b1;
        step(1);
        chk("br.pc", InstrAddr, 32'h10);
        chk("br.valid", {31'b0, ValidD}, 32'h0);
        chk("br.instr", InstrD, 32'h13);
        chk("br.count", FetchCount, 32'd5);
        PCSrc = 2'b00; Stall = 1'b0;
        step(1);
        chk("br.next", InstrD, 32'hA000_0010);

        // JALR to a misaligned target; fault stays set
        ALUResultE = 32'h103; PCSrc = 2'b10;
        step(1);
        chk("jalr.pc", InstrAddr, 32'h100);
        chk("jalr.fault", {31'b0, MisalignFault}, 32'h1);
        PCSrc = 2'b00;
        step(2);
        chk("jalr.sticky", {31'b0, MisalignFault}, 32'h1);
        chk("jalr.pc2", InstrAddr, 32'h108);

        // PC wrap at the top of the address space
        ALUResultE = 32'hFFFF_FFFC; PCSrc = 2'b10;
        step(1);
        chk("wrap.pre", InstrAddr, 32'hFFFF_FFFC);
        PCSrc = 2'b11;
        step(1);
        chk("wrap.pc", InstrAddr, 32'h0);
        chk("wrap.pcp4", PCPlus4D, 32'h0);
        chk("wrap.pcd", PCD, 32'hFFFF_FFFC);
        PCSrc = 2'b00;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            Stall      = ($urandom_range(0, 3) == 0);
            PCSrc      = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            PCE        = $urandom;
            ImmExtE    = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFC) : $urandom;
            ALUResultE = $urandom;
            step(1);
        end
        PCSrc = 2'b00; Stall = 1'b0;

        // Asynchronous reset mid-cycle with a pending branch
        PCE = 32'h40; ImmExtE = 32'h0; PCSrc = 2'b01;
        #2 rst = 1'b1;
        #1;
        chk("arst.pc", InstrAddr, 32'h0);
        chk("arst.instr", InstrD, 32'h13);
        chk("arst.pcd", PCD, 32'h0);
        chk("arst.valid", {31'b0, ValidD}, 32'h0);
        chk("arst.fault", {31'b0, MisalignFault}, 32'h0);
        chk("arst.count", FetchCount, 32'h0);
        step(1);
        rst = 1'b0; PCSrc = 2'b00;
        chk("arst.addr", InstrAddr, 32'h0);
        step(1);
        chk("arst.first", InstrD, 32'hA000_0000);
        chk("arst.pc4", InstrAddr, 32'h4);
        step(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the RV32I core.
- Holds the program counter and drives the instruction-memory read address.
- Selects the next PC from sequential, branch (PC + ImmExt) or JALR (ALUResult) sources.
- Registers the fetched instruction into the IF/ID pipeline register that feeds decode and the execute datapath (PCPlus4, PC, Instr).

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) inserted on reset/flush.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- Stall  input  1  hold PC and IF/ID register (load-use hazard from decode).
- PCSrc  input  2  00 = PC+4, 01 = branch (PCE+ImmExtE), 10 = JALR (ALUResultE & ~1), 11 = reserved, treated as 00.
- PCE  input  DATA_WIDTH  PC of the instruction in execute.
- ImmExtE  input  DATA_WIDTH  sign-extended immediate of the instruction in execute.
- ALUResultE  input  DATA_WIDTH  ALU result in execute (JALR target).
- InstrAddr  output  DATA_WIDTH  instruction-memory read address, equal to current PC (combinational).
- InstrRData  input  DATA_WIDTH  instruction-memory read data, combinational read of InstrAddr.
- InstrD  output  DATA_WIDTH  registered instruction for decode.
- PCD  output  DATA_WIDTH  registered PC of InstrD.
- PCPlus4D  output  DATA_WIDTH  registered PCD+4.
- ValidD  output  1  IF/ID slot holds a real fetched instruction.
- MisalignFault  output  1  sticky: a redirect target had bits [1:0] != 0.
- FetchCount  output  32  number of instructions accepted into IF/ID.

Behaviour:
- Reset (async, immediate, while rst=1):
  - PC = RESET_PC
  - InstrD = NOP_INSTR
  - PCD = 0, PCPlus4D = 0
  - ValidD = 0, MisalignFault = 0, FetchCount = 0
- InstrAddr = PC at all times; the memory is read combinationally, giving one-cycle fetch-to-decode latency.
- Target computation:
  - Branch target = PCE + ImmExtE, modulo 2^32.
  - JALR target = (ALUResultE & ~1), modulo 2^32.
  - Sequential = PC + 4, wrapping 32'hFFFF_FFFC -> 0.
- Each rising edge, priority order:
  1. Redirect (PCSrc = 01 or 10):
     - PC <= target & ~3
     - IF/ID flushed: InstrD <= NOP_INSTR, ValidD <= 0, PCD/PCPlus4D <= 0
     - FetchCount unchanged
     - Redirect overrides Stall.
  2. Stall = 1 (no redirect): PC, InstrD, PCD, PCPlus4D, ValidD and FetchCount all hold.
  3. Normal:
     - InstrD <= InstrRData, PCD <= PC, PCPlus4D <= PC+4, ValidD <= 1
     - PC <= PC+4
     - FetchCount <= FetchCount+1, wrapping at 2^32.
- MisalignFault:
  - Set on any redirect edge whose unmasked target has bits [1:0] != 0; for JALR this means (ALUResultE & ~1)[1] = 1.
  - Cleared only by rst. The PC still loads the masked target.
- PCSrc = 11 behaves exactly as 00.
- Reset asserted mid-operation discards any pending redirect or stall. The first edge after rst deasserts performs a normal fetch from RESET_PC.
- Pipeline state:
  - Implemented as a 2-state FSM: RUN, and FLUSHED (entered on redirect, exits to RUN on the next non-stalled edge).
  - ValidD = 0 in FLUSHED, or after reset until the first normal fetch.

Test Plan:
- Reset then 3 normal cycles, memory returns 0xA0000000|addr:
  - InstrAddr sequence 0, 4, 8
  - After edge 3: PCD = 8, PCPlus4D = 12, InstrD = 0xA0000008, ValidD = 1, FetchCount = 3.
- Stall held 2 cycles at PC = 0x10: PC stays 0x10, IF/ID outputs and FetchCount unchanged. On release, InstrD = word at 0x10 and PC = 0x14.
- Branch with PCE = 0x20, ImmExtE = 0xFFFF_FFF0 (-16), PCSrc = 01, Stall = 1 simultaneously:
  - PC = 0x10, ValidD = 0, InstrD = 0x00000013
  - FetchCount unchanged; the next edge fetches 0x10.
- JALR with ALUResultE = 0x0000_0103, PCSrc = 10: PC = 0x100, MisalignFault = 1, and it remains 1 across later normal fetches until rst.
- Wrap: PC = 0xFFFF_FFFC, normal edge gives PC = 0 and PCPlus4D = 0. FetchCount preset near 0xFFFF_FFFF wraps to 0.
- Assert rst asynchronously mid-cycle while PCSrc = 01: outputs return to reset values before the next edge, and the first post-reset InstrAddr = RESET_PC.
